// File: rtl/sd_add_redundancy_ctrl.sv
// Temporal-redundancy controller: runs the shared signed-digit adder twice (A,B then B,A) and checks agreement.
// Optional macro SDA_RETRY_EN re-executes the pass pair up to MAX_RETRY times after a mismatch.
module sd_add_redundancy_ctrl #(
    parameter int unsigned SETTLE    = 1,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_cin,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_cin,
    input  logic [7:0] add_result,
    input  logic       add_cout,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_cout,
    output logic       rsp_err,
    output logic [7:0] err_count,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_CMP  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    // Out-of-range parameters leave this marker block in the elaborated hierarchy.
    if (SETTLE < 1 || SETTLE > 15 || MAX_RETRY > 7) begin : g_illegal_params
    end

    state_t     r_state;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_cin;
    logic [8:0] r_r1;
    logic [8:0] r_r2;
    logic [3:0] r_cnt;
    logic [7:0] r_add_a;
    logic [7:0] r_add_b;
    logic       r_add_cin;
    logic [7:0] r_rsp_result;
    logic       r_rsp_cout;
    logic       r_rsp_err;
    logic [7:0] r_err_count;
    logic       w_match;
    logic [7:0] w_err_next;

`ifdef SDA_RETRY_EN
    localparam logic [2:0] MAX_RETRY_L = 3'(MAX_RETRY);
    logic [2:0] r_retry;
`endif

    assign w_match    = (r_r1 == r_r2);
    assign w_err_next = (r_err_count == 8'hFF) ? 8'hFF : r_err_count + 8'd1;

    // Both handshakes are valid/ready: a transfer happens on a rising edge where both are high;
    // valid never depends combinationally on ready, and the payload is held stable while valid waits.
    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign rsp_valid  = (r_state == S_RESP);
    assign add_a      = r_add_a;
    assign add_b      = r_add_b;
    assign add_cin    = r_add_cin;
    assign rsp_result = r_rsp_result;
    assign rsp_cout   = r_rsp_cout;
    assign rsp_err    = r_rsp_err;
    assign err_count  = r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_a          <= 8'd0;
            r_b          <= 8'd0;
            r_cin        <= 1'b0;
            r_r1         <= 9'd0;
            r_r2         <= 9'd0;
            r_cnt        <= 4'd0;
            r_add_a      <= 8'd0;
            r_add_b      <= 8'd0;
            r_add_cin    <= 1'b0;
            r_rsp_result <= 8'd0;
            r_rsp_cout   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_err_count  <= 8'd0;
`ifdef SDA_RETRY_EN
            r_retry      <= 3'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_a       <= req_a;
                        r_b       <= req_b;
                        r_cin     <= req_cin;
                        r_add_a   <= req_a;
                        r_add_b   <= req_b;
                        r_add_cin <= req_cin;
                        r_cnt     <= SETTLE_M1;
                        r_state   <= S_P1;
`ifdef SDA_RETRY_EN
                        r_retry   <= 3'd0;
`endif
                    end
                end
                S_P1: begin
                    if (r_cnt == 4'd0) begin
                        r_r1    <= {add_cout, add_result};
                        r_add_a <= r_b;
                        r_add_b <= r_a;
                        r_cnt   <= SETTLE_M1;
                        r_state <= S_P2;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_P2: begin
                    if (r_cnt == 4'd0) begin
                        r_r2      <= {add_cout, add_result};
                        r_add_a   <= 8'd0;
                        r_add_b   <= 8'd0;
                        r_add_cin <= 1'b0;
                        r_state   <= S_CMP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_CMP: begin
                    r_rsp_result <= r_r1[7:0];
                    r_rsp_cout   <= r_r1[8];
                    if (w_match) begin
                        r_rsp_err <= 1'b0;
                        r_state   <= S_RESP;
                    end else begin
                        r_err_count <= w_err_next;
`ifdef SDA_RETRY_EN
                        if (r_retry < MAX_RETRY_L) begin
                            r_retry   <= r_retry + 3'd1;
                            r_add_a   <= r_a;
                            r_add_b   <= r_b;
                            r_add_cin <= r_cin;
                            r_cnt     <= SETTLE_M1;
                            r_state   <= S_P1;
                        end else begin
                            r_rsp_err <= 1'b1;
                            r_state   <= S_RESP;
                        end
`else
                        r_rsp_err <= 1'b1;
                        r_state   <= S_RESP;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sd_add_redundancy_ctrl.md
# sd_add_redundancy_ctrl

Temporal-redundancy controller for the 8-bit signed-digit adder. It accepts one add request at a time and runs the shared adder instance twice: once with operands as given, once with A and B swapped. The adder's digit recoding is symmetric, so both passes must produce identical results. It compares the two results, retries or flags an error on mismatch, and returns the checked result over a valid/ready handshake. It sits between the requesting datapath and a single external signed-digit adder instance.

## Interface
- SETTLE, 1: cycles operands are held on the adder before its outputs are sampled; legal 1..15.
- MAX_RETRY, 2: re-executions of the pass pair after a mismatch; legal 0..7; used only with SDA_RETRY_EN.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_a, req_b  in  8  operands, four 2-bit digits each.
- req_cin  in  1  carry-in.
- add_a, add_b  out  8  registered operands to the adder.
- add_cin  out  1  registered carry-in to the adder.
- add_result  in  8  adder digit result.
- add_cout  in  1  adder carry-out.
- rsp_valid  out  1  checked result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_result  out  8  result from pass 1.
- rsp_cout  out  1  carry-out from pass 1.
- rsp_err  out  1  final pass pair mismatched.
- err_count  out  8  mismatch events since reset; saturates at 255.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, P1, P2, CMP, RESP.
- IDLE: when req_valid && req_ready, latch a, b and cin, then go to P1.
- P1: add_a=a, add_b=b, add_cin=cin. After SETTLE cycles, capture {add_cout, add_result} into r1, then go to P2.
- P2: add_a=b, add_b=a, add_cin=cin. After SETTLE cycles, capture into r2, then go to CMP.
- CMP: compare all 9 bits of r1 and r2.
  - Equal: go to RESP with rsp_err=0.
  - Mismatch: increment err_count (saturating). See Configuration for the next state.
- RESP: rsp_valid=1. rsp_result, rsp_cout and rsp_err hold stable until rsp_valid && rsp_ready, then go to IDLE.
- A single settle counter is reloaded on entry to P1 and P2.
- add_a, add_b and add_cin are 0 in IDLE, CMP and RESP.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, busy=0; add_*, rsp_*, err_count, r1, r2 and the retry counter all 0.
- Reset asserted mid-operation aborts immediately. No response is issued and the latched request is discarded.
- Accept edge is cycle 0. add_* show the pass-1 operands from cycle 1. r1 is captured at edge SETTLE and r2 at edge 2*SETTLE.
- rsp_valid rises after edge 2*SETTLE+1. With SETTLE=1 that is 3 cycles after accept.
- Each retry adds 2*SETTLE+1 cycles.
- req_ready rises the cycle after the response handshake; there is no same-cycle response-to-accept bypass.
- req_valid is ignored outside IDLE.
- rsp_ready held high before rsp_valid has no effect.
- err_count at 255 stays 255 on further mismatches.

## Configuration
- SDA_RETRY_EN defined:
  - A mismatch in CMP with retry count < MAX_RETRY increments the retry count and goes back to P1.
  - Otherwise it goes to RESP with rsp_err=1.
  - The retry count clears on accept.
- SDA_RETRY_EN undefined:
  - Any mismatch goes directly to RESP with rsp_err=1.
  - MAX_RETRY is unused and no retry counter is synthesized.

## Test plan
- Reset, then idle: all outputs at reset values; req_ready=1; add_a=add_b=0.
- Fault-free model, SETTLE=1, a=0x05, b=0x11, cin=0:
  - add_a/add_b = 0x05/0x11 in cycle 1 and 0x11/0x05 in cycle 2.
  - rsp_valid in cycle 3 with rsp_result=0x40, rsp_cout=0, rsp_err=0, err_count=0.
- Back-pressure: rsp_ready held low 5 cycles, then high. rsp_* stay stable throughout, req_ready=0 throughout, and req_ready returns 1 the cycle after the handshake.
- Transient fault, SDA_RETRY_EN, SETTLE=1:
  - Bench flips add_result[0] on the first P2 only.
  - Expect one retry, rsp_valid in cycle 6, rsp_err=0, err_count=1.
- Permanent fault, SDA_RETRY_EN, MAX_RETRY=2: flip add_result[0] whenever add_a==0x11. Expect rsp_err=1, err_count=3, rsp_valid in cycle 9. Without the macro: rsp_err=1 in cycle 3 and err_count=1.
- Reset pulse during P2, then request a=0x00, b=0x00, cin=0: no stale response appears. The new request gives rsp_result=0x00, rsp_cout=0, rsp_err=0.
